// File: rtl/hd44780_bus_writer.sv
// rtl/hd44780_bus_writer.sv - HD44780 write-only bus cycle generator timed by divided-clock ticks
// Optional feature macro: HD44780_FOUR_BIT_EN (4-bit bus, two E pulses per byte)
module hd44780_bus_writer #(
    parameter int SETUP_TICKS      = 1,
    parameter int E_HIGH_TICKS     = 2,
    parameter int HOLD_TICKS       = 1,
    parameter int NIBBLE_GAP_TICKS = 1,
    parameter int CMD_WAIT_TICKS   = 40,
    parameter int LONG_WAIT_TICKS  = 1640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_clk,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db
);
    localparam int MAX_WAIT = (LONG_WAIT_TICKS > CMD_WAIT_TICKS) ? LONG_WAIT_TICKS : CMD_WAIT_TICKS;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
`ifdef HD44780_FOUR_BIT_EN
        S_GAP,
`endif
        S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    data_q, data_d;
    logic          lcd_e_q, lcd_e_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic [7:0]    lcd_db_q, lcd_db_d;
    logic          wr_ready_q, wr_ready_d;
    logic          sync1_q, sync2_q, sync3_q;
    logic          sync1_d, sync2_d, sync3_d;
    logic          tick;
    logic          long_wait;
`ifdef HD44780_FOUR_BIT_EN
    logic          nib_q, nib_d;
`endif

    assign sync1_d   = tick_clk;
    assign sync2_d   = sync1_q;
    assign sync3_d   = sync2_q;
    assign tick      = sync2_q & ~sync3_q;
    // Clear display / return home need the long execution wait
    assign long_wait = ~rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        data_d   = data_q;
        lcd_e_d  = lcd_e_q;
        lcd_rs_d = lcd_rs_q;
        lcd_db_d = lcd_db_q;
`ifdef HD44780_FOUR_BIT_EN
        nib_d    = nib_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (wr_valid && wr_ready_q) begin
                    rs_d     = wr_rs;
                    data_d   = wr_data;
                    lcd_rs_d = wr_rs;
`ifdef HD44780_FOUR_BIT_EN
                    lcd_db_d = {wr_data[7:4], 4'h0};
                    nib_d    = 1'b0;
`else
                    lcd_db_d = wr_data;
`endif
                    cnt_d    = CW'(SETUP_TICKS);
                    state_d  = S_SETUP;
                end
            end
            default: begin
                // Entry edge always loads the count, so a tick coinciding with entry is ignored
                if (tick) begin
                    if (cnt_q != CW'(1)) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        case (state_q)
                            S_SETUP: begin
                                lcd_e_d = 1'b1;
                                cnt_d   = CW'(E_HIGH_TICKS);
                                state_d = S_EHIGH;
                            end
                            S_EHIGH: begin
                                lcd_e_d = 1'b0;
                                cnt_d   = CW'(HOLD_TICKS);
                                state_d = S_HOLD;
                            end
                            S_HOLD: begin
`ifdef HD44780_FOUR_BIT_EN
                                if (!nib_q) begin
                                    cnt_d   = CW'(NIBBLE_GAP_TICKS);
                                    state_d = S_GAP;
                                end else begin
                                    cnt_d   = long_wait ? CW'(LONG_WAIT_TICKS) : CW'(CMD_WAIT_TICKS);
                                    state_d = S_WAIT;
                                end
`else
                                cnt_d   = long_wait ? CW'(LONG_WAIT_TICKS) : CW'(CMD_WAIT_TICKS);
                                state_d = S_WAIT;
`endif
                            end
`ifdef HD44780_FOUR_BIT_EN
                            S_GAP: begin
                                nib_d    = 1'b1;
                                lcd_db_d = {data_q[3:0], 4'h0};
                                cnt_d    = CW'(SETUP_TICKS);
                                state_d  = S_SETUP;
                            end
`endif
                            default: begin
                                state_d = S_IDLE;
                            end
                        endcase
                    end
                end
            end
        endcase
        wr_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_db_q   <= 8'h00;
            wr_ready_q <= 1'b1;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
`ifdef HD44780_FOUR_BIT_EN
            nib_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            lcd_e_q    <= lcd_e_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_db_q   <= lcd_db_d;
            wr_ready_q <= wr_ready_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sync3_q    <= sync3_d;
`ifdef HD44780_FOUR_BIT_EN
            nib_q      <= nib_d;
`endif
        end
    end

    assign wr_ready = wr_ready_q;
    assign busy     = ~wr_ready_q;
    assign lcd_e    = lcd_e_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_db   = lcd_db_q;
endmodule

// File: tb/tb_hd44780_bus_writer.sv
// tb/tb_hd44780_bus_writer.sv - self-checking bench for hd44780_bus_writer against a tick-level model
module tb_hd44780_bus_writer;
    localparam int SETUP = 1, EH = 2, HOLD = 1, GAP = 1, CMD = 40, LONG = 1640;
    localparam int TPER  = 6;
    localparam int LIMIT = 20000;
`ifdef HD44780_FOUR_BIT_EN
    localparam int NPULSE = 2;
`else
    localparam int NPULSE = 1;
`endif

    logic       clk = 1'b0, rst = 1'b0, tick_clk = 1'b0;
    logic       wr_valid = 1'b0, wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, busy, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_db;

    int errors = 0;
    int checks = 0;

    hd44780_bus_writer dut (
        .clk(clk), .rst(rst), .tick_clk(tick_clk),
        .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
        .wr_ready(wr_ready), .busy(busy),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;

    // Divided clock: 3 clk high, 3 clk low; freezes at its current level when tick_en is low
    bit tick_en = 1'b1;
    int phase = 0;
    initial forever begin
        @(negedge clk);
        if (tick_en) begin
            phase    = (phase + 1) % TPER;
            tick_clk = (phase < 3);
        end
    end

    logic [7:0] rise_db[$], fall_db[$];
    logic       rise_rs[$], fall_rs[$];
    int         widths[$];
    logic       e_prev = 1'b0;
    int         w = 0;
    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            rise_db.push_back(lcd_db);
            rise_rs.push_back(lcd_rs);
            w = 1;
        end else if (lcd_e) begin
            w++;
        end
        if (!lcd_e && e_prev) begin
            widths.push_back(w);
            fall_db.push_back(lcd_db);
            fall_rs.push_back(lcd_rs);
        end
        e_prev = lcd_e;
    end

    function automatic int model_ticks(logic rs, logic [7:0] d);
        int t = SETUP + EH + HOLD;
`ifdef HD44780_FOUR_BIT_EN
        t += GAP + SETUP + EH + HOLD;
`endif
        t += (!rs && (d == 8'h01 || d == 8'h02)) ? LONG : CMD;
        return t;
    endfunction

    function automatic logic [7:0] exp_bus(logic [7:0] d, int idx);
`ifdef HD44780_FOUR_BIT_EN
        return (idx == 0) ? {d[7:4], 4'h0} : {d[3:0], 4'h0};
`else
        return (idx == 0) ? d : 8'hxx;
`endif
    endfunction

    task automatic clear_mon();
        rise_db.delete(); fall_db.delete(); rise_rs.delete(); fall_rs.delete(); widths.delete();
    endtask

    // Issue one request and count clk edges from accept until wr_ready returns
    task automatic do_write(input logic rs, input logic [7:0] d, output int k);
        int n = 0;
        clear_mon();
        while (!wr_ready && n < LIMIT) begin @(negedge clk); n++; end
        wr_valid = 1'b1; wr_rs = rs; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
        k = 0;
        while (busy && k < LIMIT) begin @(negedge clk); k++; end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({wr_ready, busy, lcd_e, lcd_rs, lcd_rw, lcd_db} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b busy=%b e=%b rs=%b rw=%b db=%h, want 1 0 0 0 0 00",
                     wr_ready, busy, lcd_e, lcd_rs, lcd_rw, lcd_db);
        end
        @(negedge clk); rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic_write();
        int k, n;
        do_write(1'b1, 8'h41, k);
        n = model_ticks(1'b1, 8'h41);
        checks++;
        if (k < TPER*(n-1)+1 || k > TPER*n) begin
            errors++; $display("FAIL basic_busy: got %0d clk, want %0d..%0d", k, TPER*(n-1)+1, TPER*n);
        end
        checks++;
        if (widths.size() != NPULSE) begin
            errors++; $display("FAIL basic_pulses: got %0d, want %0d", widths.size(), NPULSE);
        end else begin
            for (int i = 0; i < NPULSE; i++) begin
                checks++;
                if (rise_db[i] !== exp_bus(8'h41, i) || fall_db[i] !== exp_bus(8'h41, i) ||
                    rise_rs[i] !== 1'b1 || fall_rs[i] !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_bus[%0d]: got db %h/%h rs %b/%b, want db %h rs 1",
                             i, rise_db[i], fall_db[i], rise_rs[i], fall_rs[i], exp_bus(8'h41, i));
                end
                checks++;
                if (widths[i] < EH*TPER-1 || widths[i] > EH*TPER+1) begin
                    errors++; $display("FAIL basic_e_width[%0d]: got %0d clk, want %0d+/-1", i, widths[i], EH*TPER);
                end
            end
        end
    endtask

    task automatic test_long_wait();
        logic       rs_t[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] d_t[3]  = '{8'h01, 8'h38, 8'h01};
        int k, n;
        for (int i = 0; i < 3; i++) begin
            do_write(rs_t[i], d_t[i], k);
            n = model_ticks(rs_t[i], d_t[i]);
            checks++;
            if (k < TPER*(n-1)+1 || k > TPER*n) begin
                errors++;
                $display("FAIL wait_len rs=%b d=%h: got %0d clk, want %0d..%0d",
                         rs_t[i], d_t[i], k, TPER*(n-1)+1, TPER*n);
            end
        end
    endtask

    task automatic test_random();
        logic       rs;
        logic [7:0] d;
        int k, n;
        for (int it = 0; it < 6; it++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            if (!rs && (d == 8'h01 || d == 8'h02)) d = 8'h38;
            repeat ($urandom_range(0, 7)) @(negedge clk);
            do_write(rs, d, k);
            n = model_ticks(rs, d);
            checks++;
            if (k < TPER*(n-1)+1 || k > TPER*n) begin
                errors++; $display("FAIL rand_busy rs=%b d=%h: got %0d clk, want %0d..%0d", rs, d, k, TPER*(n-1)+1, TPER*n);
            end
            checks++;
            if (widths.size() != NPULSE || lcd_rw !== 1'b0) begin
                errors++; $display("FAIL rand_pulses: got %0d pulses rw=%b, want %0d pulses rw=0", widths.size(), lcd_rw, NPULSE);
            end else begin
                for (int i = 0; i < NPULSE; i++) begin
                    checks++;
                    if (rise_db[i] !== exp_bus(d, i) || fall_db[i] !== exp_bus(d, i) ||
                        rise_rs[i] !== rs || fall_rs[i] !== rs) begin
                        errors++;
                        $display("FAIL rand_bus[%0d]: got db %h/%h rs %b/%b, want db %h rs %b",
                                 i, rise_db[i], fall_db[i], rise_rs[i], fall_rs[i], exp_bus(d, i), rs);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        clear_mon();
        while (!wr_ready && k < LIMIT) begin @(negedge clk); k++; end
        wr_valid = 1'b1; wr_rs = 1'b0; wr_data = 8'h11;
        @(negedge clk);
        wr_data = 8'h22;
        k = 0;
        while (!wr_ready && k < LIMIT) begin @(negedge clk); k++; end
        checks++;
        if (widths.size() != NPULSE || rise_db.size() != NPULSE || rise_db[0] !== exp_bus(8'h11, 0)) begin
            errors++;
            $display("FAIL b2b_first: got %0d pulses first db %h, want %0d pulses db %h",
                     widths.size(), (rise_db.size() > 0) ? rise_db[0] : 8'hxx, NPULSE, exp_bus(8'h11, 0));
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || lcd_db !== exp_bus(8'h22, 0)) begin
            errors++; $display("FAIL b2b_accept: got busy=%b db=%h, want busy=1 db=%h", busy, lcd_db, exp_bus(8'h22, 0));
        end
        wr_valid = 1'b0;
        k = 0;
        while (busy && k < LIMIT) begin @(negedge clk); k++; end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_done: busy still %b after %0d clk", busy, k);
        end
    endtask

    task automatic test_reset_abort();
        int k = 0, n;
        while (!wr_ready && k < LIMIT) begin @(negedge clk); k++; end
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h33;
        @(negedge clk); wr_valid = 1'b0;
        k = 0;
        while (!lcd_e && k < 200) begin @(negedge clk); k++; end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (lcd_e !== 1'b0 || lcd_db !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_async: got e=%b db=%h busy=%b, want e=0 db=00 busy=0", lcd_e, lcd_db, busy);
        end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        do_write(1'b1, 8'h33, k);
        n = model_ticks(1'b1, 8'h33);
        checks++;
        if (k < TPER*(n-1)+1 || k > TPER*n || widths.size() != NPULSE || rise_db[0] !== exp_bus(8'h33, 0)) begin
            errors++;
            $display("FAIL abort_recover: got %0d clk %0d pulses, want %0d..%0d clk %0d pulses db %h",
                     k, widths.size(), TPER*(n-1)+1, TPER*n, NPULSE, exp_bus(8'h33, 0));
        end
    endtask

    task automatic test_freeze();
        int k = 0;
        clear_mon();
        while (!wr_ready && k < LIMIT) begin @(negedge clk); k++; end
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h5a;
        @(negedge clk); wr_valid = 1'b0;
        k = 0;
        while (!lcd_e && k < 200) begin @(negedge clk); k++; end
        tick_en = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (lcd_e !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL freeze_hold: got e=%b busy=%b, want e=1 busy=1", lcd_e, busy);
        end
        tick_en = 1'b1;
        k = 0;
        while (busy && k < LIMIT) begin @(negedge clk); k++; end
        checks++;
        if (busy !== 1'b0 || widths.size() != NPULSE) begin
            errors++; $display("FAIL freeze_resume: got busy=%b pulses=%0d, want busy=0 pulses=%0d", busy, widths.size(), NPULSE);
        end
    endtask

    initial begin
        test_reset();
        test_basic_write();
        test_long_wait();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_freeze();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
